// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op encodings, FSM state encoding,
// lane widths and small op-classification helpers.
package lsu_pkg;

  localparam int WORD_W = 32;
  localparam int HALF_W = 16;
  localparam int BYTE_W = 8;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  function automatic logic is_store(input logic [2:0] op);
    return op >= OP_SW;
  endfunction

  // Sub-word stores must fetch the word first and merge into it.
  function automatic logic is_rmw(input logic [2:0] op);
    return (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_LW, OP_SW:         bad = (offset != 2'b00);
      OP_LH, OP_LHU, OP_SH: bad = offset[0];
      default:              bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: extracts and extends loaded bytes/halfwords and
// merges store data into a fetched word (little-endian lanes).
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [1:0]        offset,
  input  logic [WORD_W-1:0] mem_word,
  input  logic [WORD_W-1:0] store_data,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] merged_word
);

  logic [BYTE_W-1:0] byte_sel;
  logic [HALF_W-1:0] half_sel;

  always_comb begin
    byte_sel = mem_word[offset*BYTE_W +: BYTE_W];
    half_sel = offset[1] ? mem_word[WORD_W-1:HALF_W] : mem_word[HALF_W-1:0];
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    load_data = mem_word;
    case (op)
      OP_LH:   load_data = {{(WORD_W-HALF_W){half_sel[HALF_W-1]}}, half_sel};
      OP_LHU:  load_data = {{(WORD_W-HALF_W){1'b0}}, half_sel};
      OP_LB:   load_data = {{(WORD_W-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
      OP_LBU:  load_data = {{(WORD_W-BYTE_W){1'b0}}, byte_sel};
      default: load_data = mem_word;
    endcase
  end

  always_comb begin
    merged_word = mem_word;
    case (op)
      OP_SW: merged_word = store_data;
      OP_SH: begin
        if (offset[1]) merged_word[WORD_W-1:HALF_W] = store_data[HALF_W-1:0];
        else           merged_word[HALF_W-1:0]      = store_data[HALF_W-1:0];
      end
      OP_SB:   merged_word[offset*BYTE_W +: BYTE_W] = store_data[BYTE_W-1:0];
      default: merged_word = mem_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE/READ/WRITE/RESP sequencer over a word-wide memory.
// Define LSU_ALIGN_CHECK_EN to flag misaligned accesses instead of force-aligning.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [WORD_W-1:0] mem_rdata
);

  logic [1:0]        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic [WORD_W-1:0] lane_load, lane_merged;
  logic              misaligned;

  lsu_byte_lane u_lane (
    .op          (op_q),
    .offset      (addr_q[1:0]),
    .mem_word    (mem_rdata),
    .store_data  (wdata_q),
    .load_data   (lane_load),
    .merged_word (lane_merged)
  );

`ifdef LSU_ALIGN_CHECK_EN
  logic err_q, err_d;
  assign misaligned = is_misaligned(req_op, req_addr[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef LSU_ALIGN_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
`ifdef LSU_ALIGN_CHECK_EN
          err_d   = misaligned;
`endif
          if (misaligned)            state_d = ST_RESP;
          else if (req_op == OP_SW)  state_d = ST_WRITE;
          else                       state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (is_rmw(op_q)) begin
          wdata_d = lane_merged;
          state_d = ST_WRITE;
        end else begin
          rdata_d = lane_load;
          state_d = ST_RESP;
        end
      end
      ST_WRITE: state_d = ST_RESP;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef LSU_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign resp_err = resp_valid & err_q;
`else
  assign resp_err = 1'b0;
`endif

  assign req_ready  = (state_q == ST_IDLE);
  assign mem_read   = (state_q == ST_READ);
  assign mem_write  = (state_q == ST_WRITE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  // Low address bits are dropped here, which is what force-aligns word accesses.
  assign mem_addr   = {2'b00, addr_q[WORD_W-1:2]};
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit; honours LSU_ALIGN_CHECK_EN when defined.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [0:15];
  logic [31:0] shadow [0:15];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[3:0]];
  always @(posedge clk) if (mem_write) mem[mem_addr[3:0]] <= mem_wdata;

  load_store_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  function automatic logic exp_misaligned(input logic [2:0] op, input logic [31:0] addr);
`ifdef LSU_ALIGN_CHECK_EN
    if (op == OP_LW || op == OP_SW) return addr[1:0] != 2'b00;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return addr[0];
`endif
    return 1'b0;
  endfunction

  // Reference model over the shadow memory; updates shadow for stores.
  function automatic void model(input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] rd,
                                output logic err);
    logic [31:0] w, mask, ins;
    logic [7:0]  b;
    logic [15:0] h;
    int          sh_b, sh_h;
    err = exp_misaligned(op, addr);
    rd  = 32'h0;
    if (err) return;
    w    = shadow[addr[5:2]];
    sh_b = 8 * int'(addr[1:0]);
    sh_h = addr[1] ? 16 : 0;
    b    = 8'(w >> sh_b);
    h    = 16'(w >> sh_h);
    case (op)
      OP_LW:  rd = w;
      OP_LH:  rd = h[15] ? {16'hFFFF, h} : {16'h0000, h};
      OP_LHU: rd = {16'h0000, h};
      OP_LB:  rd = b[7] ? {24'hFFFFFF, b} : {24'h000000, b};
      OP_LBU: rd = {24'h000000, b};
      OP_SW:  shadow[addr[5:2]] = wd;
      OP_SH: begin
        mask = 32'h0000FFFF << sh_h;
        ins  = (wd & 32'h0000FFFF) << sh_h;
        shadow[addr[5:2]] = (w & ~mask) | ins;
      end
      default: begin
        mask = 32'h000000FF << sh_b;
        ins  = (wd & 32'h000000FF) << sh_b;
        shadow[addr[5:2]] = (w & ~mask) | ins;
      end
    endcase
  endfunction

  task automatic do_access(input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp_rd,
                           input logic exp_err, input string name);
    exp_t e, got;
    int   lat, nrd, nwr, exp_rd_n, exp_wr_n;
    bit   done;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.lat   = exp_err ? 1 : ((op == OP_SH || op == OP_SB) ? 3 : 2);
    exp_rd_n = (exp_err || op == OP_SW) ? 0 : 1;
    exp_wr_n = (!exp_err && op >= OP_SW) ? 1 : 0;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_idle: got %b want 1", name, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = ~op; req_addr = ~addr; req_wdata = ~wd;
    lat = 0; nrd = 0; nwr = 0; done = 0;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
      if (mem_read) nrd++;
      if (mem_write) nwr++;
      if (mem_read || mem_write) begin
        n_checks++;
        if ((mem_read && mem_write) || mem_addr > 32'd15) begin
          n_fail++; $display("FAIL %s strobe: rd=%b wr=%b addr=%h", name, mem_read, mem_write, mem_addr);
        end
      end
      n_checks++;
      if (req_ready !== 1'b0) begin
        n_fail++; $display("FAIL %s ready_busy: got %b want 0", name, req_ready);
      end
      if (resp_valid === 1'b1) done = 1;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout: no resp_valid within 10 cycles", name);
      void'(sb.pop_front());
    end else begin
      got = sb.pop_front();
      n_checks++;
      if (lat != got.lat) begin
        n_fail++; $display("FAIL %s latency: got %0d want %0d", name, lat, got.lat);
      end
      n_checks++;
      if (resp_rdata !== got.rdata) begin
        n_fail++; $display("FAIL %s rdata: got %h want %h", name, resp_rdata, got.rdata);
      end
      n_checks++;
      if (resp_err !== got.err) begin
        n_fail++; $display("FAIL %s err: got %b want %b", name, resp_err, got.err);
      end
    end
    n_checks++;
    if (nrd != exp_rd_n || nwr != exp_wr_n) begin
      n_fail++; $display("FAIL %s strobe_count: reads %0d/%0d writes %0d/%0d", name, nrd, exp_rd_n, nwr, exp_wr_n);
    end
    @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s resp_pulse: valid=%b ready=%b want 0/1", name, resp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({req_ready, resp_valid, resp_err, mem_read, mem_write} !== 5'b10000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 10000", {req_ready, resp_valid, resp_err, mem_read, mem_write});
    end
    n_checks++;
    if ({resp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
      n_fail++; $display("FAIL reset_data: rdata=%h addr=%h wdata=%h want 0", resp_rdata, mem_addr, mem_wdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_load_byte();
    mem[1] = 32'h8899AABB;
    do_access(OP_LB, 32'h5, 32'h0, 32'hFFFFFFAA, 1'b0, "lb");
    do_access(OP_LBU, 32'h7, 32'h0, 32'h00000088, 1'b0, "lbu");
  endtask

  task automatic test_store_byte();
    mem[2] = 32'h11223344;
    do_access(OP_SB, 32'hA, 32'h000000EE, 32'h0, 1'b0, "sb");
    n_checks++;
    if (mem[2] !== 32'h11EE3344) begin
      n_fail++; $display("FAIL sb_mem: got %h want 11ee3344", mem[2]);
    end
  endtask

  task automatic test_store_load_word();
    do_access(OP_SW, 32'hC, 32'hDEADBEEF, 32'h0, 1'b0, "sw");
    do_access(OP_LW, 32'hC, 32'h0, 32'hDEADBEEF, 1'b0, "lw");
  endtask

  task automatic test_halfword();
    mem[1] = 32'h80017FFF;
    do_access(OP_LH, 32'h6, 32'h0, 32'hFFFF8001, 1'b0, "lh");
    do_access(OP_LHU, 32'h6, 32'h0, 32'h00008001, 1'b0, "lhu");
    do_access(OP_LH, 32'h4, 32'h0, 32'h00007FFF, 1'b0, "lh_lo");
  endtask

  task automatic test_misaligned();
    mem[0] = 32'h01234567;
`ifdef LSU_ALIGN_CHECK_EN
    do_access(OP_LW, 32'h2, 32'h0, 32'h0, 1'b1, "lw_misaligned");
    do_access(OP_SW, 32'h1, 32'hCAFEF00D, 32'h0, 1'b1, "sw_misaligned");
    n_checks++;
    if (mem[0] !== 32'h01234567) begin
      n_fail++; $display("FAIL sw_misaligned_mem: got %h want 01234567", mem[0]);
    end
`else
    do_access(OP_LW, 32'h2, 32'h0, 32'h01234567, 1'b0, "lw_forcealign");
`endif
  endtask

  task automatic test_reset_mid_op();
    mem[1] = 32'h80017FFF;
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_SH; req_addr = 32'h6; req_wdata = 32'h0000BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_read !== 1'b1) begin
      n_fail++; $display("FAIL midreset_read: got %b want 1", mem_read);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset_ready: got %b want 1", req_ready);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (resp_valid !== 1'b0 || mem_write !== 1'b0) begin
        n_fail++; $display("FAIL midreset_quiet: valid=%b write=%b want 0/0", resp_valid, mem_write);
      end
      @(negedge clk);
    end
    n_checks++;
    if (mem[1] !== 32'h80017FFF) begin
      n_fail++; $display("FAIL midreset_mem: got %h want 80017fff", mem[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, addr, wd;
    logic [2:0]  op;
    logic        err;
    for (int i = 4; i < 8; i++) begin
      shadow[i] = $urandom;
      mem[i] = shadow[i];
    end
    for (int n = 0; n < 24; n++) begin
      op   = 3'($urandom_range(0, 7));
      addr = 32'($urandom_range(16, 31));
      wd   = $urandom;
      model(op, addr, wd, rd, err);
      do_access(op, addr, wd, rd, err, "random");
    end
    for (int i = 4; i < 8; i++) begin
      n_checks++;
      if (mem[i] !== shadow[i]) begin
        n_fail++; $display("FAIL random_mem[%0d]: got %h want %h", i, mem[i], shadow[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    test_reset();
    test_load_byte();
    test_store_byte();
    test_store_load_word();
    test_halfword();
    test_misaligned();
    test_reset_mid_op();
    test_back_to_back();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
